// File: rtl/xt_keyboard_pkg.sv
// Shared types and constants for the XT keyboard receiver.
// Consumed by the receiver top and its testbench-facing interface.
package xt_keyboard_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    HOLD
  } state_e;

  localparam int   KEYCODE_WIDTH   = 8;
  localparam int   DATA_BITS       = 8;
  localparam int   COUNT_WIDTH     = 4;
  localparam logic START_BIT_VALUE = 1'b1;

endpackage

// File: rtl/xt_keyboard_receiver_if.sv
// Keyboard line, 8255 control and interrupt signals of the XT receiver.
// master = keyboard/PPI side, slave = receiver.
interface xt_keyboard_receiver_if;
  import xt_keyboard_pkg::*;

  logic                     kbd_clock_in;
  logic                     kbd_data_in;
  logic                     clear_keycode;
  logic                     clock_enable;
  logic [KEYCODE_WIDTH-1:0] keycode;
  logic                     irq;
  logic                     kbd_clock_pull_low;

  modport master (
    output kbd_clock_in,
    output kbd_data_in,
    output clear_keycode,
    output clock_enable,
    input  keycode,
    input  irq,
    input  kbd_clock_pull_low
  );

  modport slave (
    input  kbd_clock_in,
    input  kbd_data_in,
    input  clear_keycode,
    input  clock_enable,
    output keycode,
    output irq,
    output kbd_clock_pull_low
  );

endinterface

// File: rtl/xt_keyboard_sync.sv
// Synchroniser for keyboard clock/data plus a registered falling-edge
// detector; data is registered alongside the edge flag.
module xt_keyboard_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clk_async_i,
  input  logic data_async_i,
  output logic sync_data_o,
  output logic clk_fall_o
);

  logic [STAGES-1:0] clk_sync_q;
  logic [STAGES-1:0] data_sync_q;
  logic              clk_prev_q;
  logic              fall_q;
  logic              data_q;

  // Clock line idles high, so reset it high to avoid a false edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q  <= '1;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b1;
      fall_q      <= 1'b0;
      data_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[STAGES-2:0], clk_async_i};
      data_sync_q <= {data_sync_q[STAGES-2:0], data_async_i};
      clk_prev_q  <= clk_sync_q[STAGES-1];
      fall_q      <= clk_prev_q & ~clk_sync_q[STAGES-1];
      data_q      <= data_sync_q[STAGES-1];
    end
  end

  assign sync_data_o = data_q;
  assign clk_fall_o  = fall_q;

endmodule

// File: rtl/xt_keyboard_receiver.sv
// PC/XT keyboard serial receiver feeding 8255 port A and IRQ1.
// Optional inter-bit timeout: define XT_KEYBOARD_TIMEOUT_EN.
module xt_keyboard_receiver
  import xt_keyboard_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMER_WIDTH    = 17
) (
  input logic                  clock,
  input logic                  reset,
  xt_keyboard_receiver_if.slave kbd
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if ($clog2(TIMEOUT_CYCLES) > TIMER_WIDTH) begin : g_bad_timer
    $error("TIMER_WIDTH too small for TIMEOUT_CYCLES");
  end

  logic sync_data;
  logic clk_fall;

  xt_keyboard_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i        (clock),
    .rst_i        (reset),
    .clk_async_i  (kbd.kbd_clock_in),
    .data_async_i (kbd.kbd_data_in),
    .sync_data_o  (sync_data),
    .clk_fall_o   (clk_fall)
  );

  state_e                   state_q, state_d;
  logic [KEYCODE_WIDTH-1:0] shift_q, shift_d;
  logic [COUNT_WIDTH-1:0]   bit_count_q, bit_count_d;
  logic [KEYCODE_WIDTH-1:0] keycode_q, keycode_d;
  logic                     irq_q, irq_d;
  logic                     pull_q, pull_d;

`ifdef XT_KEYBOARD_TIMEOUT_EN
  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST =
    TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_count_q <= '0;
      keycode_q   <= '0;
      irq_q       <= 1'b0;
      pull_q      <= 1'b0;
`ifdef XT_KEYBOARD_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_count_q <= bit_count_d;
      keycode_q   <= keycode_d;
      irq_q       <= irq_d;
      pull_q      <= pull_d;
`ifdef XT_KEYBOARD_TIMEOUT_EN
      timer_q     <= timer_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_count_d = bit_count_q;
    keycode_d   = keycode_q;
    irq_d       = irq_q;
`ifdef XT_KEYBOARD_TIMEOUT_EN
    timer_d     = timer_q;
`endif

    if (kbd.clear_keycode) begin
      state_d     = IDLE;
      shift_d     = '0;
      bit_count_d = '0;
      keycode_d   = '0;
      irq_d       = 1'b0;
`ifdef XT_KEYBOARD_TIMEOUT_EN
      timer_d     = '0;
`endif
    end else if (!kbd.clock_enable) begin
      // Inhibit drops the frame but keeps a delivered code.
      state_d     = IDLE;
      shift_d     = '0;
      bit_count_d = '0;
`ifdef XT_KEYBOARD_TIMEOUT_EN
      timer_d     = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clk_fall && sync_data == START_BIT_VALUE) begin
            state_d     = RECEIVE;
            shift_d     = '0;
            bit_count_d = '0;
`ifdef XT_KEYBOARD_TIMEOUT_EN
            timer_d     = '0;
`endif
          end
        end
        RECEIVE: begin
          if (clk_fall) begin
            shift_d     = {sync_data, shift_q[KEYCODE_WIDTH-1:1]};
            bit_count_d = bit_count_q + 1'b1;
`ifdef XT_KEYBOARD_TIMEOUT_EN
            timer_d     = '0;
`endif
            if (bit_count_q == COUNT_WIDTH'(DATA_BITS - 1)) begin
              keycode_d = shift_d;
              irq_d     = 1'b1;
              state_d   = HOLD;
            end
          end
`ifdef XT_KEYBOARD_TIMEOUT_EN
          else if (timer_q == TIMEOUT_LAST) begin
            state_d     = IDLE;
            shift_d     = '0;
            bit_count_d = '0;
            timer_d     = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
`endif
        end
        HOLD: begin
          state_d = HOLD;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    pull_d = (state_d == HOLD) | ~kbd.clock_enable;
  end

  assign kbd.keycode            = keycode_q;
  assign kbd.irq                = irq_q;
  assign kbd.kbd_clock_pull_low = pull_q;

endmodule
